// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage of the pipelined MIPS-style core. It owns the program
// counter and drives it straight to the asynchronous-read instruction memory.
// The returned word is captured into the IF/ID pipeline register. Stall,
// branch and jump redirects from later stages are applied here.
//
// Parameters:
//   RESET_PC  - PC loaded on reset (word aligned)
//   MEM_WORDS - number of 32-bit words backed by instruction memory
//   NOP       - instruction word inserted on flush or invalid fetch
//
// Ports:
//   clk           in   single clock, rising-edge updates
//   rst           in   synchronous active-high reset
//   pc            out  byte address to instruction memory (the PC register)
//   instr         in   memory read data for the current pc
//   stall         in   hazard unit holds the fetch stage
//   branch_taken  in   resolved branch redirect (highest priority)
//   branch_target in   branch target byte address
//   jump          in   jump redirect
//   jump_target   in   jump target byte address
//   if_id_instr   out  registered instruction to decode
//   if_id_pc4     out  registered PC+4 of that instruction
//   if_id_valid   out  if_id_instr is a real fetched instruction
//   addr_err      out  sticky misaligned-redirect / out-of-range flag
//   fetch_count   out  number of valid instructions latched into IF/ID
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 65,
  parameter logic [31:0] NOP       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        addr_err,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        target_misaligned;
  logic        pc_in_range;

  assign pc = pc_q;

  // Sequential PC increment; the 32-bit adder wraps naturally past FFFF_FFFC.
  assign pc_plus4 = pc_q + 32'd4;

  // A branch outranks a jump, so jump_target is ignored when both arrive.
  // Stall is deliberately absent here: a redirect always wins over a stall.
  always_comb begin
    redirect        = branch_taken | jump;
    redirect_target = branch_taken ? branch_target : jump_target;
  end

  assign target_misaligned = redirect && (redirect_target[1:0] != 2'b00);

  // The range check looks at the word index of the PC currently on the bus,
  // widened so a large MEM_WORDS compares correctly against all 30 bits.
  assign pc_in_range = ({2'b00, pc_q[31:2]} < MEM_WORDS);

  // Single state block for the PC and the IF/ID register. Priority is reset,
  // then redirect (which flushes IF/ID and keeps the old pc4), then stall
  // (everything holds), then a normal advance. On an out-of-range fetch the
  // PC still moves forward but a bubble is latched and the error flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      if_id_instr <= NOP;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
      addr_err    <= 1'b0;
      fetch_count <= 32'd0;
    end else if (redirect) begin
      pc_q        <= {redirect_target[31:2], 2'b00};
      if_id_instr <= NOP;
      if_id_valid <= 1'b0;
      if (target_misaligned) begin
        addr_err <= 1'b1;
      end
    end else if (!stall) begin
      pc_q      <= pc_plus4;
      if_id_pc4 <= pc_plus4;
      if (pc_in_range) begin
        if_id_instr <= instr;
        if_id_valid <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end else begin
        if_id_instr <= NOP;
        if_id_valid <= 1'b0;
        addr_err    <= 1'b1;
      end
    end
  end

endmodule
